// File: rtl/but_addr_gen.sv
// Operand-fetch / write-back address generator for the 256-point radix-4 DIF engine.
// Four cache reads per cycle, twiddle exponents for rotfac1..4, flush control between
// stages and in-place write addresses delayed to line up with the butterfly output.
// Optional feature macro: AGU_STALL_EN (adds stall_i, freezes the engine while high).
module but_addr_gen #(
  parameter int unsigned RD_LAT  = 1,  // cache read latency, 1..4
  parameter int unsigned GAP_CYC = 2   // idle cycles between stages, >= RD_LAT+1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
`ifdef AGU_STALL_EN
  input  logic       stall_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] stage_o,
  output logic       rd_en_o,
  output logic [7:0] rd_addr0_o,
  output logic [7:0] rd_addr1_o,
  output logic [7:0] rd_addr2_o,
  output logic [7:0] rd_addr3_o,
  output logic [7:0] tw_exp0_o,
  output logic [7:0] tw_exp1_o,
  output logic [7:0] tw_exp2_o,
  output logic [7:0] tw_exp3_o,
  output logic       flush_flag_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr0_o,
  output logic [7:0] wr_addr1_o,
  output logic [7:0] wr_addr2_o,
  output logic [7:0] wr_addr3_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StGap   = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [5:0] b_q, b_d;
  logic [1:0] stage_q, stage_d;
  logic [7:0] cnt_q, cnt_d;
  logic       active;
  logic       stall_w;
  logic       run_raw;

  logic [7:0] rd_addr_q [4];
  logic [7:0] tw_q      [4];
  logic [7:0] addr_d    [4];
  logic [7:0] tw_d      [4];
  logic [2:0] sh;
  logic [5:0] g;
  logic [5:0] kmask;
  logic [5:0] k;

  logic [RD_LAT-1:0] wen_q;
  logic [7:0]        wa_q [RD_LAT][4];

  assign active  = (state_q == StRun) || (state_q == StGap) || (state_q == StDrain);
  assign run_raw = (state_q == StRun);

`ifdef AGU_STALL_EN
  assign stall_w = stall_i & active;
`else
  assign stall_w = 1'b0;
`endif

  // Next-state logic for the stage sequencer; everything holds while stalled.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (!stall_w) begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StRun;
            b_d     = 6'd0;
            stage_d = 2'd0;
          end
        end
        StRun: begin
          b_d = b_q + 6'd1;  // wraps to 0 ready for the next stage
          if (b_q == 6'd63) begin
            cnt_d = 8'd0;
            if (stage_q == 2'd3) begin
              state_d = StDrain;
            end else begin
              state_d = StGap;
              stage_d = stage_q + 2'd1;
            end
          end
        end
        StGap: begin
          if (cnt_q == 8'(GAP_CYC - 1)) state_d = StRun;
          else                          cnt_d   = cnt_q + 8'd1;
        end
        StDrain: begin
          if (cnt_q == 8'(RD_LAT - 1)) state_d = StDone;
          else                         cnt_d   = cnt_q + 8'd1;
        end
        StDone: begin
          state_d = StIdle;
          stage_d = 2'd0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Addresses and exponents for the butterfly issued next cycle.
  // L = 4^(3-stage) is a shift of sh = 2*(3-stage); 3-stage == ~stage for 2 bits.
  always_comb begin
    sh    = {~stage_d, 1'b0};
    g     = b_d >> sh;
    kmask = (6'd1 << sh) - 6'd1;
    k     = b_d & kmask;
    for (int i = 0; i < 4; i++) begin
      addr_d[i] = ({2'b00, g} << (4'(sh) + 4'd2)) + {2'b00, k} + (8'(i) << sh);
      tw_d[i]   = (8'(i) * {2'b00, k}) << {stage_d, 1'b0};
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      b_q     <= 6'd0;
      stage_q <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered read addresses / exponents; they hold outside RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        rd_addr_q[i] <= 8'd0;
        tw_q[i]      <= 8'd0;
      end
    end else if (!stall_w && state_d == StRun) begin
      for (int i = 0; i < 4; i++) begin
        rd_addr_q[i] <= addr_d[i];
        tw_q[i]      <= tw_d[i];
      end
    end
  end

  // Write-back delay line; keeps shifting through GAP/DRAIN so the last reads retire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wen_q <= '0;
      for (int j = 0; j < RD_LAT; j++) begin
        for (int i = 0; i < 4; i++) wa_q[j][i] <= 8'd0;
      end
    end else if (!stall_w) begin
      wen_q[0] <= run_raw;
      for (int i = 0; i < 4; i++) wa_q[0][i] <= rd_addr_q[i];
      for (int j = 1; j < RD_LAT; j++) begin
        wen_q[j] <= wen_q[j-1];
        for (int i = 0; i < 4; i++) wa_q[j][i] <= wa_q[j-1][i];
      end
    end
  end

  assign busy_o       = active;
  assign done_o       = (state_q == StDone);
  assign stage_o      = stage_q;
  assign flush_flag_o = (state_q == StGap) || (state_q == StDrain);
  assign rd_en_o      = run_raw & ~stall_w;
  assign wr_en_o      = wen_q[RD_LAT-1] & ~stall_w;

  assign rd_addr0_o = rd_addr_q[0];
  assign rd_addr1_o = rd_addr_q[1];
  assign rd_addr2_o = rd_addr_q[2];
  assign rd_addr3_o = rd_addr_q[3];
  assign tw_exp0_o  = tw_q[0];
  assign tw_exp1_o  = tw_q[1];
  assign tw_exp2_o  = tw_q[2];
  assign tw_exp3_o  = tw_q[3];
  assign wr_addr0_o = wa_q[RD_LAT-1][0];
  assign wr_addr1_o = wa_q[RD_LAT-1][1];
  assign wr_addr2_o = wa_q[RD_LAT-1][2];
  assign wr_addr3_o = wa_q[RD_LAT-1][3];

endmodule

// File: tb/tb_but_addr_gen.sv
// Self-checking bench for but_addr_gen: timeline model plus read/write scoreboards.
module tb_but_addr_gen;

  localparam int RdLat   = 1;
  localparam int GapCyc  = 2;
  localparam int Seg     = 64 + GapCyc;
  localparam int DoneCyc = 256 + 3 * GapCyc + RdLat + 1;

  logic       clk = 1'b0;
  logic       rst, start;
`ifdef AGU_STALL_EN
  logic       stall;
`endif
  logic       busy, done, rd_en, flush, wr_en;
  logic [1:0] stage;
  logic [7:0] ra0, ra1, ra2, ra3, tw0, tw1, tw2, tw3, wa0, wa1, wa2, wa3;

  always #5 clk = ~clk;

  but_addr_gen #(.RD_LAT(RdLat), .GAP_CYC(GapCyc)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
`ifdef AGU_STALL_EN
    .stall_i      (stall),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .stage_o      (stage),
    .rd_en_o      (rd_en),
    .rd_addr0_o   (ra0),
    .rd_addr1_o   (ra1),
    .rd_addr2_o   (ra2),
    .rd_addr3_o   (ra3),
    .tw_exp0_o    (tw0),
    .tw_exp1_o    (tw1),
    .tw_exp2_o    (tw2),
    .tw_exp3_o    (tw3),
    .flush_flag_o (flush),
    .wr_en_o      (wr_en),
    .wr_addr0_o   (wa0),
    .wr_addr1_o   (wa1),
    .wr_addr2_o   (wa2),
    .wr_addr3_o   (wa3)
  );

  typedef struct {
    int stg;
    int a[4];
    int t[4];
  } vec_t;

  vec_t         rd_q[$];
  vec_t         wr_q[$];
  bit   [255:0] seen[4];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk4(input int a0, input int a1, input int a2, input int a3);
    return {8'(a0), 8'(a1), 8'(a2), 8'(a3)};
  endfunction

  // Reference butterfly: plain divide/modulo arithmetic.
  function automatic vec_t mk_vec(input int s, input int b);
    vec_t v;
    int   l, g, k;
    l = 1;
    for (int j = 0; j < 3 - s; j++) l = l * 4;
    g = b / l;
    k = b % l;
    v.stg = s;
    for (int i = 0; i < 4; i++) begin
      v.a[i] = g * 4 * l + k + i * l;
      v.t[i] = i * k * (64 / (l * l / (l * l) * (64 / (4 ** s))));
    end
    return v;
  endfunction

  // Expected control outputs at effective cycle te after start (start at te=0).
  task automatic expect_at(input int te, output bit ren, output bit bsy, output bit dn,
                           output bit fl, output int stg);
    int tp, s, off;
    ren = 0; bsy = 0; dn = 0; fl = 0; stg = 0;
    if (te == DoneCyc) begin
      dn = 1; stg = 3;
    end else if (te >= 1 && te < DoneCyc) begin
      tp  = te - 1;
      s   = tp / Seg;
      off = tp % Seg;
      if (s >= 3) begin
        s   = 3;
        off = tp - 3 * Seg;
      end
      ren = (off < 64);
      fl  = !ren;
      bsy = 1;
      stg = ren ? s : ((s < 3) ? s + 1 : 3);
    end
  endtask

  task automatic chk_zero(input string tag);
    check_eq({tag, "_ctl"}, {26'd0, busy, done, stage, rd_en, flush, wr_en}, 32'd0);
    check_eq({tag, "_rd"}, {ra0, ra1, ra2, ra3}, 32'd0);
    check_eq({tag, "_tw"}, {tw0, tw1, tw2, tw3}, 32'd0);
    check_eq({tag, "_wr"}, {wa0, wa1, wa2, wa3}, 32'd0);
  endtask

  task automatic run_xform(input bit spot, input bit pulses, input int rst_cyc,
                           input int st_lo, input int st_hi);
    vec_t v;
    int   nst, te, stg, done_cnt, done_at, n_stall, max_c;
    bit   ren, bsy, dn, fl, wren, d1, d2, d3, stl;
    int   d4;
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < 4; s++) begin
      seen[s] = '0;
      for (int b = 0; b < 64; b++) rd_q.push_back(mk_vec(s, b));
    end
    n_stall  = (st_lo > 0) ? (st_hi - st_lo + 1) : 0;
    max_c    = DoneCyc + n_stall + 4;
    nst      = 0;
    done_cnt = 0;
    done_at  = -1;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= max_c; c++) begin
      @(posedge clk); #1;
      start = pulses && (c == 10 || c == 100);
      rst   = (c == rst_cyc);
      stl   = (c >= st_lo && c <= st_hi);
`ifdef AGU_STALL_EN
      stall = stl;
`endif
      @(negedge clk);
      if (c == rst_cyc + 1) begin
        chk_zero("abort");
        return;
      end
      te = c - nst;
      expect_at(te, ren, bsy, dn, fl, stg);
      expect_at(te - RdLat, wren, d1, d2, d3, d4);
      if (stl) begin
        ren  = 0;
        wren = 0;
        nst++;
      end
      check_eq("rd_en", 32'(rd_en), 32'(ren));
      check_eq("wr_en", 32'(wr_en), 32'(wren));
      check_eq("busy", 32'(busy), 32'(bsy));
      check_eq("done", 32'(done), 32'(dn));
      check_eq("flush", 32'(flush), 32'(fl));
      if (te <= DoneCyc) check_eq("stage", 32'(stage), 32'(stg));
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          check_eq("rd_extra", 32'd1, 32'd0);
        end else begin
          v = rd_q.pop_front();
          check_eq("rd_addr", {ra0, ra1, ra2, ra3}, pk4(v.a[0], v.a[1], v.a[2], v.a[3]));
          check_eq("tw_exp", {tw0, tw1, tw2, tw3}, pk4(v.t[0], v.t[1], v.t[2], v.t[3]));
          check_eq("rd_stage", 32'(stage), 32'(v.stg));
          wr_q.push_back(v);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check_eq("wr_extra", 32'd1, 32'd0);
        end else begin
          v = wr_q.pop_front();
          check_eq("wr_addr", {wa0, wa1, wa2, wa3}, pk4(v.a[0], v.a[1], v.a[2], v.a[3]));
          for (int i = 0; i < 4; i++) begin
            check_eq("wr_dup", 32'(seen[v.stg][v.a[i]]), 32'd0);
            seen[v.stg][v.a[i]] = 1'b1;
          end
        end
      end
      if (spot) begin
        if (c == 1) begin
          check_eq("t1_rd", {ra0, ra1, ra2, ra3}, pk4(0, 64, 128, 192));
          check_eq("t1_tw", {tw0, tw1, tw2, tw3}, 32'd0);
        end
        if (c == 2) begin
          check_eq("t2_rd_b1", {ra0, ra1, ra2, ra3}, pk4(1, 65, 129, 193));
          check_eq("t2_tw_b1", {tw0, tw1, tw2, tw3}, pk4(0, 1, 2, 3));
        end
        if (c == 64) begin
          check_eq("t2_rd_b63", {ra0, ra1, ra2, ra3}, pk4(63, 127, 191, 255));
          check_eq("t2_tw_b63", {tw0, tw1, tw2, tw3}, pk4(0, 63, 126, 189));
        end
        if (c == 65 + GapCyc + 17) begin
          check_eq("t3_rd_s1b17", {ra0, ra1, ra2, ra3}, pk4(65, 81, 97, 113));
          check_eq("t3_tw_s1b17", {tw0, tw1, tw2, tw3}, pk4(0, 4, 8, 12));
        end
        if (c == 1 + 3 * Seg + 5) begin
          check_eq("t3_rd_s3b5", {ra0, ra1, ra2, ra3}, pk4(20, 21, 22, 23));
          check_eq("t3_tw_s3b5", {tw0, tw1, tw2, tw3}, 32'd0);
        end
      end
    end
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("done_cycle", 32'(done_at), 32'(DoneCyc + n_stall));
    check_eq("rd_left", 32'(rd_q.size()), 32'd0);
    check_eq("wr_left", 32'(wr_q.size()), 32'd0);
    for (int s = 0; s < 4; s++) check_eq("wr_cover", 32'($countones(seen[s])), 32'd256);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
`ifdef AGU_STALL_EN
    stall = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle");
    run_xform(1'b1, 1'b0, -10, -1, -2);
    run_xform(1'b0, 1'b1, 150, -1, -2);
    run_xform(1'b0, 1'b0, -10, -1, -2);
`ifdef AGU_STALL_EN
    run_xform(1'b0, 1'b0, -10, 30, 34);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
